// File: rtl/datamem_pkg.sv
// Shared constants and types for the N-port data memory.
package datamem_pkg;
  localparam int DEF_NUM_PORTS  = 3;
  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LINE_BYTES = 64;
  localparam int DEF_RR_MODE    = 0;

  typedef enum logic [1:0] {IDLE, BURST, DONE} line_state_t;
  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_t;

  // Index width that stays legal for a single-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/datamem_nport_if.sv
// Narrow request/response ports plus the wide line read channel.
interface datamem_nport_if
  import datamem_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LINE_BYTES = DEF_LINE_BYTES
);
  localparam int BE_W = DATA_W / 8;

  logic [NUM_PORTS-1:0]             req_valid;
  logic [NUM_PORTS-1:0]             req_wr;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_PORTS-1:0][BE_W-1:0]   req_be;
  logic [NUM_PORTS-1:0]             req_ready;
  logic [NUM_PORTS-1:0]             rsp_valid;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rsp_rdata;
  logic                             line_rd_en;
  logic [ADDR_W-1:0]                line_addr;
  logic                             line_busy;
  logic                             line_rd_valid;
  logic [LINE_BYTES*8-1:0]          line_rd_data;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_be, line_rd_en, line_addr,
    input  req_ready, rsp_valid, rsp_rdata, line_busy, line_rd_valid, line_rd_data
  );
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_be, line_rd_en, line_addr,
    output req_ready, rsp_valid, rsp_rdata, line_busy, line_rd_valid, line_rd_data
  );
endinterface

// File: rtl/datamem_arbiter.sv
// One-hot grant over SLOTS requesters; fixed priority or round-robin from ptr.
module datamem_arbiter
  import datamem_pkg::*;
#(
  parameter int        SLOTS = 4,
  parameter arb_mode_t MODE  = ARB_FIXED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SLOTS-1:0] req,
  output logic [SLOTS-1:0] gnt
);
  localparam int PW = idx_w(SLOTS);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] gnt_idx;
  logic [PW:0]   sum;
  logic          any;

  // Walk slots starting at ptr (RR) or 0 (fixed); first requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    sum     = '0;
    for (int k = 0; k < SLOTS; k++) begin
      sum = (MODE == ARB_RR) ? {1'b0, ptr_q} + (PW+1)'(k) : (PW+1)'(k);
      if (sum >= (PW+1)'(SLOTS)) sum = sum - (PW+1)'(SLOTS);
      if (!any && req[sum[PW-1:0]]) begin
        any                = 1'b1;
        gnt[sum[PW-1:0]]   = 1'b1;
        gnt_idx            = sum[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr_q <= '0;
    else if (MODE == ARB_RR && any)
      ptr_q <= (gnt_idx == PW'(SLOTS-1)) ? '0 : gnt_idx + PW'(1);
  end
endmodule

// File: rtl/datamem_nport.sv
// Byte-addressed memory shared by NUM_PORTS narrow requesters and a wide line reader.
module datamem_nport
  import datamem_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int RR_MODE    = DEF_RR_MODE
) (
  input  logic            clk,
  input  logic            rst_n,
  datamem_nport_if.slave  bus
);
  localparam int        BE_W  = DATA_W / 8;
  localparam int        BEATS = LINE_BYTES / BE_W;
  localparam int        BW    = idx_w(BEATS);
  localparam int        SLOTS = NUM_PORTS + 1;
  localparam arb_mode_t MODE  = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

  logic [7:0]              mem [0:(1<<ADDR_W)-1];
  line_state_t             state_q, state_d;
  logic [ADDR_W-1:0]       base_q;
  logic [BW-1:0]           beat_q;
  logic [SLOTS-1:0]        req, gnt;
  logic [ADDR_W-1:0]       sel_addr;
  logic [DATA_W-1:0]       sel_wdata, rd_word;
  logic [BE_W-1:0]         sel_be;
  logic                    sel_wr, wide_gnt, last_beat;
  logic [LINE_BYTES*8-1:0] line_q;

  // The wide slot sits above all narrow ports so fixed priority serves it last.
  assign req = {state_q == BURST, bus.req_valid};

  datamem_arbiter #(.SLOTS(SLOTS), .MODE(MODE)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  assign bus.req_ready = gnt[NUM_PORTS-1:0];
  assign wide_gnt      = gnt[NUM_PORTS];
  assign last_beat     = (beat_q == BW'(BEATS-1));

  always_comb begin
    sel_addr  = base_q + ADDR_W'(int'(beat_q) * BE_W);
    sel_wdata = '0;
    sel_be    = '0;
    sel_wr    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt[i]) begin
        sel_addr  = bus.req_addr[i];
        sel_wdata = bus.req_wdata[i];
        sel_be    = bus.req_be[i];
        sel_wr    = bus.req_wr[i];
      end
    end
  end

  // Unaligned word read; byte addresses wrap at the top of memory.
  always_comb begin
    rd_word = '0;
    for (int b = 0; b < BE_W; b++)
      rd_word[b*8 +: 8] = mem[sel_addr + ADDR_W'(b)];
  end

  always_ff @(posedge clk) begin
    if (sel_wr) begin
      for (int b = 0; b < BE_W; b++)
        if (sel_be[b]) mem[sel_addr + ADDR_W'(b)] <= sel_wdata[b*8 +: 8];
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_rsp
    logic              v_q;
    logic [DATA_W-1:0] d_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else begin
        v_q <= gnt[i] && !bus.req_wr[i];
        if (gnt[i] && !bus.req_wr[i]) d_q <= rd_word;
      end
    end

    assign bus.rsp_valid[i] = v_q;
    assign bus.rsp_rdata[i] = d_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.line_rd_en) state_d = BURST;
      BURST:   if (wide_gnt && last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      beat_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.line_rd_en) begin
        base_q <= bus.line_addr;
        beat_q <= '0;
      end else if (wide_gnt) begin
        line_q[int'(beat_q)*DATA_W +: DATA_W] <= rd_word;
        beat_q <= last_beat ? '0 : beat_q + BW'(1);
      end
    end
  end

  assign bus.line_busy     = (state_q != IDLE);
  assign bus.line_rd_valid = (state_q == DONE);
  assign bus.line_rd_data  = line_q;
endmodule

// File: tb/tb_datamem_nport.sv
// Directed bench: one fixed-priority and one round-robin instance on a shared clock/reset.
module tb_datamem_nport;
  import datamem_pkg::*;

  localparam int NP = 3, AW = 16, DW = 32, LB = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [LB*8-1:0] exp_line;

  datamem_nport_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .LINE_BYTES(LB)) fb ();
  datamem_nport_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .LINE_BYTES(LB)) rb ();

  datamem_nport #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .LINE_BYTES(LB), .RR_MODE(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .bus(fb));
  datamem_nport #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .LINE_BYTES(LB), .RR_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .bus(rb));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr_all();
    fb.req_valid = '0; fb.req_wr = '0; fb.req_addr = '0; fb.req_wdata = '0; fb.req_be = '0;
    fb.line_rd_en = 1'b0; fb.line_addr = '0;
    rb.req_valid = '0; rb.req_wr = '0; rb.req_addr = '0; rb.req_wdata = '0; rb.req_be = '0;
    rb.line_rd_en = 1'b0; rb.line_addr = '0;
  endtask

  task automatic fdrv(input int p, input logic wr, input logic [15:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    fb.req_valid[p] = 1'b1;
    fb.req_wr[p]    = wr;
    fb.req_addr[p]  = a;
    fb.req_wdata[p] = d;
    fb.req_be[p]    = be;
  endtask

  task automatic wait_line(output int n);
    n = 1;
    while (!fb.line_rd_valid && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    clr_all();
    rst_n = 1'b0;
    repeat (2) tick();
    tests_run++;
    if (fb.req_ready !== 3'b000) begin tests_failed++; $display("FAIL reset_ready got=%b exp=000", fb.req_ready); end
    tests_run++;
    if (fb.rsp_valid !== 3'b000) begin tests_failed++; $display("FAIL reset_rsp_valid got=%b exp=000", fb.rsp_valid); end
    tests_run++;
    if (fb.rsp_rdata !== '0) begin tests_failed++; $display("FAIL reset_rsp_rdata got=%h exp=0", fb.rsp_rdata); end
    tests_run++;
    if (fb.line_busy !== 1'b0 || fb.line_rd_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_line_flags got busy=%b valid=%b exp=0 0", fb.line_busy, fb.line_rd_valid);
    end
    tests_run++;
    if (fb.line_rd_data !== '0) begin tests_failed++; $display("FAIL reset_line_data got=%h exp=0", fb.line_rd_data); end
    tests_run++;
    if (rb.rsp_rdata !== '0 || rb.line_busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_rr_outputs got rdata=%h busy=%b exp=0 0", rb.rsp_rdata, rb.line_busy);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fixed_priority();
    fdrv(0, 1'b1, 16'h0004, 32'hDEADBEEF, 4'hF);
    fdrv(1, 1'b1, 16'h0004, 32'h11111111, 4'hF);
    fdrv(2, 1'b0, 16'h0004, 32'h0, 4'h0);
    settle();
    tests_run++;
    if (fb.req_ready !== 3'b001) begin tests_failed++; $display("FAIL fixed_grant got=%b exp=001", fb.req_ready); end
    tick();
    clr_all();
    tests_run++;
    if (fb.rsp_valid !== 3'b000) begin tests_failed++; $display("FAIL fixed_no_rsp got=%b exp=000", fb.rsp_valid); end
    fdrv(1, 1'b0, 16'h0004, 32'h0, 4'h0);
    settle();
    tests_run++;
    if (fb.req_ready !== 3'b010) begin tests_failed++; $display("FAIL fixed_p1_grant got=%b exp=010", fb.req_ready); end
    tick();
    clr_all();
    tests_run++;
    if (fb.rsp_valid !== 3'b010) begin tests_failed++; $display("FAIL fixed_p1_rsp_valid got=%b exp=010", fb.rsp_valid); end
    tests_run++;
    if (fb.rsp_rdata[1] !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL fixed_p1_rdata got=%h exp=deadbeef", fb.rsp_rdata[1]); end
    tick();
    tests_run++;
    if (fb.rsp_valid !== 3'b000 || fb.rsp_rdata[1] !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL fixed_rsp_hold got valid=%b data=%h exp=000 deadbeef", fb.rsp_valid, fb.rsp_rdata[1]);
    end
  endtask

  task automatic test_be_wrap();
    fdrv(0, 1'b1, 16'hFFFE, 32'hAABBCCDD, 4'hF); tick(); clr_all();
    fdrv(0, 1'b0, 16'hFFFE, 32'h0, 4'h0); tick(); clr_all();
    tests_run++;
    if (fb.rsp_rdata[0][15:0] !== 16'hCCDD) begin tests_failed++; $display("FAIL wrap_lo got=%h exp=ccdd", fb.rsp_rdata[0][15:0]); end
    fdrv(0, 1'b0, 16'h0000, 32'h0, 4'h0); tick(); clr_all();
    tests_run++;
    if (fb.rsp_rdata[0][15:0] !== 16'hAABB) begin tests_failed++; $display("FAIL wrap_hi got=%h exp=aabb", fb.rsp_rdata[0][15:0]); end
    fdrv(0, 1'b1, 16'hFFFE, 32'h00000000, 4'b0001); tick(); clr_all();
    fdrv(0, 1'b0, 16'hFFFE, 32'h0, 4'h0); tick(); clr_all();
    tests_run++;
    if (fb.rsp_rdata[0] !== 32'hAABBCC00) begin tests_failed++; $display("FAIL be_partial got=%h exp=aabbcc00", fb.rsp_rdata[0]); end
  endtask

  task automatic test_rr_sequence();
    logic [2:0] exp;
    rb.req_valid = 3'b111;
    for (int c = 0; c < 8; c++) begin
      exp = 3'b001 << (c % 3);
      settle();
      tests_run++;
      if (rb.req_ready !== exp) begin tests_failed++; $display("FAIL rr_grant[%0d] got=%b exp=%b", c, rb.req_ready, exp); end
      tick();
      tests_run++;
      if (rb.rsp_valid !== exp) begin tests_failed++; $display("FAIL rr_rsp[%0d] got=%b exp=%b", c, rb.rsp_valid, exp); end
    end
    clr_all();
    tick();
  endtask

  task automatic fill_line();
    for (int w = 0; w < 16; w++) begin
      fdrv(0, 1'b1, 16'(16'h0100 + 4*w), {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, 4'hF);
      tick();
      clr_all();
    end
  endtask

  task automatic test_wide();
    int n;
    fill_line();
    fb.line_rd_en = 1'b1; fb.line_addr = 16'h0100;
    tick();
    fb.line_rd_en = 1'b0;
    tests_run++;
    if (fb.line_busy !== 1'b1) begin tests_failed++; $display("FAIL wide_busy got=%b exp=1", fb.line_busy); end
    wait_line(n);
    tests_run++;
    if (n != 17) begin tests_failed++; $display("FAIL wide_latency got=%0d exp=17", n); end
    tests_run++;
    if (fb.line_rd_data !== exp_line) begin tests_failed++; $display("FAIL wide_data got=%h exp=%h", fb.line_rd_data, exp_line); end
    tick();
    tests_run++;
    if (fb.line_busy !== 1'b0 || fb.line_rd_valid !== 1'b0) begin
      tests_failed++; $display("FAIL wide_idle got busy=%b valid=%b exp=0 0", fb.line_busy, fb.line_rd_valid);
    end
  endtask

  task automatic test_contention_fixed();
    int n;
    fb.line_rd_en = 1'b1; fb.line_addr = 16'h0100;
    tick();
    fb.line_rd_en = 1'b0;
    fdrv(2, 1'b0, 16'h0100, 32'h0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      settle();
      tests_run++;
      if (fb.req_ready !== 3'b100 || fb.line_rd_valid !== 1'b0) begin
        tests_failed++; $display("FAIL starve[%0d] got ready=%b valid=%b exp=100 0", i, fb.req_ready, fb.line_rd_valid);
      end
      tick();
    end
    clr_all();
    wait_line(n);
    tests_run++;
    if (n != 17) begin tests_failed++; $display("FAIL starve_release_latency got=%0d exp=17", n); end
    tests_run++;
    if (fb.line_rd_data !== exp_line) begin tests_failed++; $display("FAIL starve_data got=%h exp=%h", fb.line_rd_data, exp_line); end
    tick();
  endtask

  task automatic test_contention_rr();
    int n;
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    rb.line_rd_en = 1'b1; rb.line_addr = 16'h0100;
    tick();
    rb.line_rd_en = 1'b0;
    rb.req_valid[2] = 1'b1; rb.req_addr[2] = 16'h0100;
    settle();
    tests_run++;
    if (rb.req_ready !== 3'b100) begin tests_failed++; $display("FAIL rr_wide_c1 got=%b exp=100", rb.req_ready); end
    tick();
    settle();
    tests_run++;
    if (rb.req_ready !== 3'b000) begin tests_failed++; $display("FAIL rr_wide_c2 got=%b exp=000", rb.req_ready); end
    n = 2;
    while (!rb.line_rd_valid && n < 80) begin
      tick();
      n++;
    end
    tests_run++;
    if (n != 33) begin tests_failed++; $display("FAIL rr_wide_latency got=%0d exp=33", n); end
    clr_all();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    int  n;
    logic saw;
    fb.line_rd_en = 1'b1; fb.line_addr = 16'h0100;
    tick();
    fb.line_rd_en = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    settle();
    tests_run++;
    if (fb.line_busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy got=%b exp=0", fb.line_busy); end
    tests_run++;
    if (fb.line_rd_data !== '0) begin tests_failed++; $display("FAIL abort_data got=%h exp=0", fb.line_rd_data); end
    tick();
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      tick();
      if (fb.line_rd_valid) saw = 1'b1;
    end
    tests_run++;
    if (saw !== 1'b0) begin tests_failed++; $display("FAIL abort_no_valid got=%b exp=0", saw); end
    fb.line_rd_en = 1'b1; fb.line_addr = 16'h0100;
    tick();
    fb.line_rd_en = 1'b0;
    wait_line(n);
    tests_run++;
    if (n != 17) begin tests_failed++; $display("FAIL after_abort_latency got=%0d exp=17", n); end
    tests_run++;
    if (fb.line_rd_data !== exp_line) begin tests_failed++; $display("FAIL after_abort_data got=%h exp=%h", fb.line_rd_data, exp_line); end
    tick();
  endtask

  initial begin
    for (int k = 0; k < LB; k++) exp_line[k*8 +: 8] = 8'(k);
    test_reset();
    test_fixed_priority();
    test_be_wrap();
    test_rr_sequence();
    test_wide();
    test_contention_fixed();
    test_contention_rr();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d tests", tests_run);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/datamem_nport.md
# datamem_nport

Parametrised N-port byte-addressed data memory with a built-in arbiter and a wide-line burst read channel. It is the successor to the three-port CPU data memory. Ports 0..NUM_PORTS-1 are narrow word requesters; by default these are EX, CPU and ACCEL, in that priority order. A separate wide channel assembles a full line for the accelerator. Arbitration is either fixed-priority or round-robin, selected by parameter, and every transfer uses a valid/ready handshake.

## Interface
Parameters:
- NUM_PORTS, 3: number of narrow requesters (2..8).
- ADDR_W, 16: byte address width; memory size is 2^ADDR_W bytes.
- DATA_W, 32: narrow word width, a multiple of 8.
- LINE_BYTES, 64: wide line size, a multiple of DATA_W/8.
- RR_MODE, 0: 0 selects fixed priority, 1 selects round-robin.

Ports:
- clk, input, 1: clock. This is the only clock domain.
- rst_n, input, 1: asynchronous active-low reset.
- req_valid, input, NUM_PORTS: per-port request valid.
- req_wr, input, NUM_PORTS: 1 for a write, 0 for a read.
- req_addr, input, NUM_PORTS*ADDR_W: byte address; port i occupies slice [i*ADDR_W +: ADDR_W].
- req_wdata, input, NUM_PORTS*DATA_W: write data, little-endian.
- req_be, input, NUM_PORTS*DATA_W/8: byte enables for writes.
- req_ready, output, NUM_PORTS: grant; the transfer happens when valid and ready are both high.
- rsp_valid, output, NUM_PORTS: read data valid, one-cycle pulse.
- rsp_rdata, output, NUM_PORTS*DATA_W: read data.
- line_rd_en, input, 1: start a wide read; sampled only in IDLE.
- line_addr, input, ADDR_W: wide read base byte address.
- line_busy, output, 1: high while the wide FSM is not in IDLE.
- line_rd_valid, output, 1: one-cycle pulse when the line is complete.
- line_rd_data, output, LINE_BYTES*8: assembled line; byte 0 is at bits [7:0].

## Operation
- Memory is a byte array and is not cleared by reset. Its contents are undefined until written.
- A word access at address A touches bytes A..A+DATA_W/8-1. Byte addresses wrap modulo 2^ADDR_W. Unaligned addresses are legal.
- Arbitration slots are 0..NUM_PORTS-1 for the narrow ports plus slot NUM_PORTS for a wide beat. The wide slot requests only while the FSM is in BURST.
- Exactly one slot is granted per cycle, and only when at least one slot requests.
- Fixed priority (RR_MODE=0): the lowest index wins and the wide slot is always last.
- Round-robin (RR_MODE=1): the search starts at ptr and wraps over all NUM_PORTS+1 slots. After each grant, ptr becomes (granted+1) mod (NUM_PORTS+1). With no grant, ptr holds.
- Granted write: the enabled bytes commit at that clock edge.
- Granted read: data is registered. rsp_valid[i] and rsp_rdata[i] appear in the cycle after the grant.
- A read granted in the cycle after a write sees the new bytes.
- A port with no response holds its last rsp_rdata value, with rsp_valid low.
- A requester must hold req_valid and all its fields stable until it is granted. Ungranted requests have no side effect.

Wide FSM states are IDLE, BURST and DONE.
- IDLE -> BURST when line_rd_en=1. On that transition the FSM latches line_addr as the base and sets beat=0.
- BURST: each wide grant reads the word at base+beat*DATA_W/8 (wrapping) into the line buffer at word position beat, then increments beat.
- BURST -> DONE after the edge that captures the final beat, beat = LINE_BYTES/(DATA_W/8) - 1.
- DONE: line_rd_valid=1 for exactly one cycle, then the FSM returns to IDLE.
- line_rd_en is ignored outside IDLE.
- Each beat samples memory at its own grant time. A burst is not an atomic snapshot.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, line_busy=0, line_rd_valid=0, line_rd_data=0, FSM=IDLE, ptr=0, beat=0.
- req_ready is combinational from req_valid, the FSM state and ptr. There is zero-cycle grant latency.
- Narrow read latency is 1 cycle after the grant.
- Wide latency with an uncontested channel:
  - line_rd_en is sampled at edge E0.
  - The 16 beats (at the default parameters) are granted in the cycles after E0, 1 through 16.
  - line_rd_valid is high in cycle 17.
  - line_busy is high from E0 until the end of DONE.
- Under fixed priority, a continuously requesting narrow port can starve the wide channel. Integrators must accept this.
- Reset asserted mid-burst aborts the burst: the FSM returns to IDLE, and outputs and ptr go to their reset values immediately. Writes already committed remain in memory.

## Structure
- Package datamem_pkg holds:
  - default parameter constants;
  - the wide FSM state typedef line_state_t, with values IDLE, BURST, DONE;
  - the mode typedef arb_mode_t, with values ARB_FIXED, ARB_RR.
- Sub-module datamem_arbiter: a (NUM_PORTS+1)-way one-hot grant generator that also holds the round-robin pointer. It is parametrised by slot count and mode.
- The top level contains the byte array, the per-port response registers, the wide FSM and the line buffer.

## Test plan
- Fixed mode, defaults:
  - Stimulus: in the same cycle, port0 writes 0xDEADBEEF to 0x0004, port1 writes 0x11111111 to 0x0004, port2 reads 0x0004.
  - Required: only req_ready=3'b001 is granted.
  - Then port1 reads 0x0004. Required: rsp_rdata[1]=0xDEADBEEF, one cycle after its grant.
- Byte enables and wrap:
  - Write 0xAABBCCDD to 0xFFFE with be=4'b1111.
  - Required: reads return 0xCCDD at byte address 0xFFFE and 0xAABB at byte address 0x0000.
  - Then write 0x00000000 to 0xFFFE with be=4'b0001. Required: bytes 0xFFFF, 0x0000 and 0x0001 are unchanged.
- Round-robin mode:
  - Stimulus: all three ports request continuously for 8 cycles.
  - Required: the grant sequence is 0,1,2,0,1,2,0,1 and rsp_valid follows one cycle later.
- Wide read:
  - Fill 0x0100..0x013F with byte value = address[7:0], then pulse line_rd_en with line_addr=0x0100 while no other requests are active.
  - Required: line_rd_valid in cycle 17, with byte k of line_rd_data equal to k.
- Wide channel under contention:
  - Fixed mode: port2 requests continuously during a burst. Required: no wide beat is granted until port2 drops.
  - RR mode: under the same stimulus, wide beats are interleaved with port2, and line_rd_valid arrives 33 cycles after E0.
- Reset mid-burst:
  - Deassert rst_n at beat 5.
  - Required: line_busy=0 and line_rd_valid is never pulsed. A new burst after reset completes normally.
